// File: rtl/led_port_ctrl_if.sv
// led_port_ctrl_if: data-memory strobe bus between the RISC core and the LED port.
// The core drives the strobes, address and write data; the port returns registered read data.
interface led_port_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/led_port_ctrl.sv
// led_port_ctrl: memory-mapped LED output port with per-bit static/blink mode
// and a software-programmable blink half-period (PRESCALE * max(PERIOD,1) clk).
// Register map: 0=DATA, 1=MODE, 2=PERIOD, 3=DUTY (reserved, reads 0, unless LEDPORT_PWM_EN).
// Define LEDPORT_PWM_EN to add an 8-bit DUTY register and free-running PWM dimming.
module led_port_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PER_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    led_port_ctrl_if.slave   bus,
    output logic [WIDTH-1:0] led_out
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_MODE   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mode_q;
    logic [PER_W-1:0] period_q;
    logic [PER_W-1:0] period_eff;
    logic [PRE_W-1:0] pre_cnt;
    logic [PER_W-1:0] blink_cnt;
    phase_t           phase;
    logic             tick;
    logic             period_wr;
    logic             pwm_gate;
    logic [15:0]      rd_val;

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign period_wr = bus.wr_en && (bus.addr == A_PERIOD);

    // A zero PERIOD behaves as one tick per half-period
    always_comb begin
        period_eff = period_q;
        if (period_q == '0) begin
            period_eff = PER_W'(1);
        end
    end

    // Software-visible DATA/MODE/PERIOD registers; upper write bits are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            mode_q   <= '0;
            period_q <= PER_W'(1);
        end else if (bus.wr_en) begin
            case (bus.addr)
                A_DATA:   data_q   <= bus.wdata[WIDTH-1:0];
                A_MODE:   mode_q   <= bus.wdata[WIDTH-1:0];
                A_PERIOD: period_q <= bus.wdata[PER_W-1:0];
                default:  ;
            endcase
        end
    end

    // Prescaler, blink counter and phase; a PERIOD write restarts the whole blink cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= PH_OFF;
        end else if (period_wr) begin
            pre_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= PH_OFF;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                if (blink_cnt == period_eff - PER_W'(1)) begin
                    blink_cnt <= '0;
                    phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
                end else begin
                    blink_cnt <= blink_cnt + PER_W'(1);
                end
            end
        end
    end

`ifdef LEDPORT_PWM_EN
    logic [7:0] duty_q;
    logic [7:0] pwm_cnt;

    // Free-running PWM counter and DUTY register; DUTY writes never disturb the counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (bus.wr_en && (bus.addr == 2'd3)) begin
                duty_q <= bus.wdata[7:0];
            end
        end
    end

    // DUTY of zero bypasses dimming entirely
    always_comb begin
        pwm_gate = (duty_q == '0) || (pwm_cnt < duty_q);
    end
`else
    // No dimming in this build
    always_comb begin
        pwm_gate = 1'b1;
    end
`endif

    // Read mux, zero-extended; address 3 is DUTY only when dimming is built in
    always_comb begin
        rd_val = '0;
        case (bus.addr)
            A_DATA:   rd_val[WIDTH-1:0] = data_q;
            A_MODE:   rd_val[WIDTH-1:0] = mode_q;
            A_PERIOD: rd_val[PER_W-1:0] = period_q;
`ifdef LEDPORT_PWM_EN
            default:  rd_val[7:0]       = duty_q;
`else
            default:  rd_val            = '0;
`endif
        endcase
    end

    // Registered read data; holds when no read is strobed, so a same-edge write returns the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rdata <= '0;
        end else if (bus.rd_en) begin
            bus.rdata <= rd_val;
        end
    end

    // Registered LED drive: static bits follow DATA, blink bits follow DATA gated by phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out <= '0;
        end else begin
            led_out <= ((data_q & ~mode_q) | (data_q & mode_q & {WIDTH{phase == PH_ON}}))
                       & {WIDTH{pwm_gate}};
        end
    end

endmodule

// File: tb/tb_led_port_ctrl.sv
// tb_led_port_ctrl: self-checking bench for led_port_ctrl (WIDTH=8, PRESCALE=4, PER_W=8).
// Register reads go through a scoreboard queue; LED timing is checked at fixed cycle offsets.
module tb_led_port_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led_out;

    led_port_ctrl_if bus();

    led_port_ctrl #(
        .WIDTH    (8),
        .PRESCALE (4),
        .PER_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    rd_exp_t     rd_e;
    logic        rd_seen;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned lit;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Read monitor: a read strobed at a rising edge is compared on the following falling edge
    always @(posedge clk) rd_seen <= bus.rd_en;

    always @(negedge clk) begin
        if (rd_seen === 1'b1) begin
            check_val("sb_nonempty", (rd_q.size() != 0), 1);
            if (rd_q.size() != 0) begin
                rd_e = rd_q.pop_front();
                check_val(rd_e.tag, bus.rdata, rd_e.exp);
            end
        end
    end

    // All tasks start and end just after a falling edge
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        rd_q.push_back('{tag, exp});
        bus.rd_en = 1'b1;
        bus.addr  = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic rdwr(input string tag, input logic [1:0] a, input logic [15:0] d,
                        input logic [15:0] exp);
        rd_q.push_back('{tag, exp});
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst       = 1'b0;

        // Reset
        #20;
        check_val("led_in_reset", led_out, 8'h00);
        #18;
        rst = 1'b1;
        @(negedge clk);
        check_val("led_after_reset", led_out, 8'h00);
        check_val("rdata_after_reset", bus.rdata, 16'h0000);
        rd("rst_period", 2'd2, 16'h0001);
        rd("rst_data", 2'd0, 16'h0000);
        rd("rst_mode", 2'd1, 16'h0000);

        // Static write, pipeline latency, read-back, hold, read-during-write
        wr(2'd0, 16'hFFA5);
        check_val("led_pipe_lag", led_out, 8'h00);
        cyc(1);
        check_val("led_static", led_out, 8'hA5);
        rd("rd_data", 2'd0, 16'h00A5);
        cyc(1);
        check_val("rdata_hold", bus.rdata, 16'h00A5);
        rdwr("rd_wr_same", 2'd0, 16'h003C, 16'h00A5);
        rd("rd_data_new", 2'd0, 16'h003C);
        cyc(1);
        check_val("led_static2", led_out, 8'h3C);
        wr(2'd1, 16'hFF0F);
        rd("rd_mode", 2'd1, 16'h000F);

        // Blink, PERIOD=3: half-period 12 clk; led_out trails phase by one edge
        wr(2'd0, 16'h00FF);
        wr(2'd2, 16'h0003);
        cyc(1);
        check_val("blink_off_start", led_out, 8'hF0);
        cyc(11);
        check_val("blink_off_w12", led_out, 8'hF0);
        cyc(1);
        check_val("blink_on_w13", led_out, 8'hFF);
        cyc(11);
        check_val("blink_on_w24", led_out, 8'hFF);
        cyc(1);
        check_val("blink_off_w25", led_out, 8'hF0);

        // PERIOD=0 acts as 1 (toggle every 4 clk); upper wdata bits ignored
        wr(2'd2, 16'hAB00);
        cyc(4);
        check_val("p0_off_w4", led_out, 8'hF0);
        cyc(1);
        check_val("p0_on_w5", led_out, 8'hFF);
        // Rewrite PERIOD while ON: phase forced off, next toggle 8 clk later
        wr(2'd2, 16'hAB02);
        cyc(1);
        check_val("rewrite_forced_off", led_out, 8'hF0);
        cyc(7);
        check_val("rewrite_off_w8", led_out, 8'hF0);
        cyc(1);
        check_val("rewrite_on_w9", led_out, 8'hFF);
        rd("rd_period", 2'd2, 16'h0002);

        // Asynchronous reset while lit
        check_val("pre_reset_on", led_out, 8'hFF);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_reset_led", led_out, 8'h00);
        @(negedge clk);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check_val("led_post_reset", led_out, 8'h00);
        rd("post_rst_mode", 2'd1, 16'h0000);
        rd("post_rst_data", 2'd0, 16'h0000);
        rd("post_rst_period", 2'd2, 16'h0001);

        // Address 3
        wr(2'd0, 16'h0001);
        cyc(2);
        check_val("led_bit0", led_out, 8'h01);
`ifdef LEDPORT_PWM_EN
        wr(2'd3, 16'h1240);
        rd("rd_duty", 2'd3, 16'h0040);
        cyc(2);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            lit += led_out[0];
        end
        check_val("pwm_lit_64", lit, 64);
        wr(2'd3, 16'h0000);
        cyc(2);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            lit += led_out[0];
        end
        check_val("pwm_bypass_256", lit, 256);
`else
        wr(2'd3, 16'hFFFF);
        rd("rd_addr3", 2'd3, 16'h0000);
        cyc(1);
        check_val("led_addr3_noeffect", led_out, 8'h01);
`endif

        cyc(2);
        check_val("sb_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
